comp_move_gen: RTL and testbench
================================

// Module: comp_move_gen
// PURPOSE
//  Computer opponent for single-player mode; sits directly upstream of memory_unit and drives its comp_inp.
//  Takes a snapshot of the board when the player's move commits, then runs a multi-cycle rule search.
//  Rule priority: win > block > centre > corner > edge.
//  Returns one cell index with a one-cycle valid pulse. Not used in two-player mode (gamemode_switch=0).
// PARAMETERS
//  EMPTY    2'b00  cell code: empty
//  PLAYER   2'b01  cell code: human mark
//  COMP     2'b10  cell code: computer mark
//  NO_MOVE  4'hF   comp_inp value when no legal move exists
// PORTS
//  clk              in   1   system clock; all logic on rising edge
//  reset            in   1   synchronous, active-low reset
//  board            in   18  cell i in board[2i+1:2i], i=0..8 row-major (0=top-left, 4=centre)
//  req              in   1   one-cycle pulse: player move committed, computer to move
//  gamemode_switch  in   1   1=single-player (block active); 0=block idle
//  comp_inp         out  4   chosen cell 0..8, or NO_MOVE; held until next result
//  comp_valid       out  1   one-cycle pulse: comp_inp is new
//  busy             out  1   high from the cycle after req is accepted until comp_valid
// BEHAVIOUR
//  Reset (reset=0 at a clock edge):
//   - state=IDLE, comp_inp=NO_MOVE, comp_valid=0, busy=0, line counter=0.
//   - Reset mid-search aborts the search; no comp_valid is produced.
//  FSM states: IDLE, WIN, BLOCK, FALLBACK, DONE.
//  IDLE:
//   - req && gamemode_switch: latch board into snap, line=0, go to WIN.
//   - Otherwise stay in IDLE.
//  Line table, fixed order:
//   - 0:{0,1,2}  1:{3,4,5}  2:{6,7,8}
//   - 3:{0,3,6}  4:{1,4,7}  5:{2,5,8}
//   - 6:{0,4,8}  7:{2,4,6}
//  WIN, one line per cycle:
//   - Hit if exactly two cells == COMP and one == EMPTY.
//   - Hit: move=that empty cell, go to DONE.
//   - Miss on line 7: line=0, go to BLOCK. Else line++.
//  BLOCK: same search with PLAYER in place of COMP. Miss on line 7 goes to FALLBACK.
//  FALLBACK, single cycle, first EMPTY wins:
//   - Check 4, then 0, 2, 6, 8, then 1, 3, 5, 7.
//   - No EMPTY cell: move=NO_MOVE.
//  DONE: comp_inp<=move, comp_valid=1 for this cycle only, busy=0, then IDLE.
//  Latency, counted in clock edges from the edge that samples req to comp_valid high:
//   - win on line L:   2+L
//   - block on line L: 10+L
//   - fallback:        18 (worst case)
//  Boundary conditions:
//   - Search uses snap only; board changes during the search are ignored.
//   - req while busy: ignored; not queued.
//   - gamemode_switch falls mid-search: abort to IDLE next edge, no comp_valid, comp_inp unchanged.
//   - Cell code 2'b11 counts as occupied and as neither mark.
//   - Several hits in one phase: lowest-numbered line wins.
//   - A win beats a block even when both exist.
//   - comp_valid never asserts on two consecutive cycles.
// STRUCTURE
//  ttt_pkg (shared with memory_unit and the display path):
//   - cell codes EMPTY/PLAYER/COMP, NO_MOVE
//   - LINE_TBL[8][3] cell indices
//   - FALLBACK_ORDER[9]
//   - FSM state encoding
//  Sub-module ttt_line_eval, combinational:
//   - in: three 2-bit cells, their three indices, target code
//   - out: hit, empty_idx[3:0]
//   - one instance, time-shared across lines via the line counter.
//  Top holds: FSM, 3-bit line counter, 18-bit snap register, fallback priority encoder, output registers.
// TESTING
//  1. snap: C C . / P P . / . . .  ->  comp_inp=2 (win line 0) at latency 2, not block at 5.
//  2. snap: P . . / . P . / . . C  ->  no win; block on line 6 needs cell 8, occupied.
//     Next empty-completion is the centre... centre is P.
//     Use instead P P . / . C . / . . .  ->  comp_inp=2 (block line 0) at latency 10.
//  3. Empty board  ->  comp_inp=4 at latency 18.
//     Centre taken, corners 0 and 2 taken  ->  comp_inp=6.
//  4. Full board, no wins  ->  comp_inp=4'hF, comp_valid pulses once at latency 18.
//  5. Abort cases:
//   - reset=0 at latency 5 of a search  ->  no comp_valid, comp_inp=4'hF.
//   - gamemode_switch=0 mid-search  ->  no comp_valid, comp_inp holds.
//  6. Request and snapshot handling:
//   - Second req during busy  ->  exactly one comp_valid.
//   - Board changed after req  ->  result matches the snapshot.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared tic-tac-toe definitions: cell codes, the eight winning lines, the
// fallback preference order, the computer-move FSM encoding and a helper that
// extracts one 2-bit cell from an 18-bit board vector.
package ttt_pkg;

  localparam logic [1:0] EMPTY   = 2'b00;
  localparam logic [1:0] PLAYER  = 2'b01;
  localparam logic [1:0] COMP    = 2'b10;
  localparam logic [3:0] NO_MOVE = 4'hF;

  // Rows, then columns, then the two diagonals; the search order matters
  // because the lowest-numbered hit wins.
  localparam logic [3:0] LINE_TBL [8][3] = '{
    '{4'd0, 4'd1, 4'd2},
    '{4'd3, 4'd4, 4'd5},
    '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6},
    '{4'd1, 4'd4, 4'd7},
    '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8},
    '{4'd2, 4'd4, 4'd6}
  };

  // Centre, then corners, then edges.
  localparam logic [3:0] FALLBACK_ORDER [9] = '{
    4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7
  };

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WIN      = 3'd1,
    BLOCK    = 3'd2,
    FALLBACK = 3'd3,
    DONE     = 3'd4
  } state_e;

  // Cell idx lives in board[2*idx+1 : 2*idx].
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [17:0] shifted;
    shifted = b >> {idx, 1'b0};
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/ttt_line_eval.sv
// Evaluates one three-cell line: hit when exactly two cells hold the target
// mark and the third is empty; empty_idx then names that empty cell.
// Ports: cell_a/b/c  - the three 2-bit cell codes
//        idx_a/b/c   - board indices of those cells
//        target      - mark being completed (COMP for win, PLAYER for block)
//        hit         - line can be completed in one move
//        empty_idx   - index of the first empty cell, NO_MOVE if none
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] cell_a,
  input  logic [1:0] cell_b,
  input  logic [1:0] cell_c,
  input  logic [3:0] idx_a,
  input  logic [3:0] idx_b,
  input  logic [3:0] idx_c,
  input  logic [1:0] target,
  output logic       hit,
  output logic [3:0] empty_idx
);

  logic [1:0] n_tgt_s;
  logic [1:0] n_empty_s;

  // Count target marks and empties; code 2'b11 matches neither.
  always_comb begin
    n_tgt_s   = {1'b0, cell_a == target} + {1'b0, cell_b == target} + {1'b0, cell_c == target};
    n_empty_s = {1'b0, cell_a == EMPTY} + {1'b0, cell_b == EMPTY} + {1'b0, cell_c == EMPTY};
    hit       = (n_tgt_s == 2'd2) && (n_empty_s == 2'd1);
    if (cell_a == EMPTY) begin
      empty_idx = idx_a;
    end else if (cell_b == EMPTY) begin
      empty_idx = idx_b;
    end else if (cell_c == EMPTY) begin
      empty_idx = idx_c;
    end else begin
      empty_idx = NO_MOVE;
    end
  end

endmodule

// File: rtl/comp_move_gen.sv
// Computer opponent for single-player mode. On req it snapshots the board and
// searches line by line for a winning move, then a blocking move, then takes
// the first empty cell in centre/corner/edge order.
// Ports: clk, reset (sync, active-low)
//        board[17:0]      - live board, cell i in board[2i+1:2i]
//        req              - player move committed, computer to move
//        gamemode_switch  - 1 = single-player; 0 aborts/idles the block
//        comp_inp[3:0]    - chosen cell or NO_MOVE, held until next result
//        comp_valid       - one-cycle pulse when comp_inp is new
//        busy             - search in progress
module comp_move_gen
  import ttt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [17:0] board,
  input  logic        req,
  input  logic        gamemode_switch,
  output logic [3:0]  comp_inp,
  output logic        comp_valid,
  output logic        busy
);

  state_e      state_r, state_s;
  logic [2:0]  line_r, line_s;
  logic [17:0] snap_r, snap_s;
  logic [3:0]  move_r, move_s;
  logic [3:0]  comp_inp_r, comp_inp_s;
  logic        comp_valid_r, comp_valid_s;
  logic        busy_r, busy_s;

  logic [1:0]  target_s;
  logic        hit_s;
  logic [3:0]  empty_idx_s;
  logic [3:0]  fb_move_s;

  assign target_s = (state_r == BLOCK) ? PLAYER : COMP;

  // Single evaluator, time-shared across lines by the line counter.
  ttt_line_eval u_line_eval (
    .cell_a    (cell_at(snap_r, LINE_TBL[line_r][0])),
    .cell_b    (cell_at(snap_r, LINE_TBL[line_r][1])),
    .cell_c    (cell_at(snap_r, LINE_TBL[line_r][2])),
    .idx_a     (LINE_TBL[line_r][0]),
    .idx_b     (LINE_TBL[line_r][1]),
    .idx_c     (LINE_TBL[line_r][2]),
    .target    (target_s),
    .hit       (hit_s),
    .empty_idx (empty_idx_s)
  );

  // Fallback priority encoder: scanned backwards so the most preferred
  // empty cell is the last one written.
  always_comb begin
    fb_move_s = NO_MOVE;
    for (int k = 8; k >= 0; k--) begin
      fb_move_s = (cell_at(snap_r, FALLBACK_ORDER[k]) == EMPTY) ? FALLBACK_ORDER[k] : fb_move_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_s      = state_r;
    line_s       = line_r;
    snap_s       = snap_r;
    move_s       = move_r;
    comp_inp_s   = comp_inp_r;
    comp_valid_s = 1'b0;
    busy_s       = busy_r;
    if (state_r == IDLE) begin
      busy_s = 1'b0;
      if (req && gamemode_switch) begin
        snap_s  = board;
        line_s  = 3'd0;
        busy_s  = 1'b1;
        state_s = WIN;
      end else begin
        state_s = IDLE;
      end
    end else if (!gamemode_switch) begin
      // Leaving single-player mode abandons the search silently.
      state_s = IDLE;
      line_s  = 3'd0;
      busy_s  = 1'b0;
    end else begin
      case (state_r)
        WIN, BLOCK: begin
          if (hit_s) begin
            move_s  = empty_idx_s;
            state_s = DONE;
          end else if (line_r == 3'd7) begin
            line_s  = 3'd0;
            state_s = (state_r == WIN) ? BLOCK : FALLBACK;
          end else begin
            line_s  = line_r + 3'd1;
          end
        end
        FALLBACK: begin
          move_s  = fb_move_s;
          state_s = DONE;
        end
        DONE: begin
          comp_inp_s   = move_r;
          comp_valid_s = 1'b1;
          busy_s       = 1'b0;
          state_s      = IDLE;
        end
        default: begin
          state_s = IDLE;
          line_s  = 3'd0;
          busy_s  = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= IDLE;
      line_r       <= 3'd0;
      snap_r       <= 18'd0;
      move_r       <= NO_MOVE;
      comp_inp_r   <= NO_MOVE;
      comp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      line_r       <= line_s;
      snap_r       <= snap_s;
      move_r       <= move_s;
      comp_inp_r   <= comp_inp_s;
      comp_valid_r <= comp_valid_s;
      busy_r       <= busy_s;
    end
  end

  assign comp_inp   = comp_inp_r;
  assign comp_valid = comp_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_comp_move_gen.sv
// Scoreboard bench for comp_move_gen: the driver pushes the expected move and
// latency for every accepted request; the monitor pops on comp_valid.
module tb_comp_move_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [17:0] board = 18'd0;
  logic        req = 1'b0;
  logic        gamemode_switch = 1'b1;
  logic [3:0]  comp_inp;
  logic        comp_valid;
  logic        busy;

  comp_move_gen dut (
    .clk             (clk),
    .reset           (reset),
    .board           (board),
    .req             (req),
    .gamemode_switch (gamemode_switch),
    .comp_inp        (comp_inp),
    .comp_valid      (comp_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         start;
    int         lat;
    logic [3:0] move;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic rst_at = 1'b0;
  logic gs_at = 1'b1;
  logic [3:0] hold_exp = 4'hF;
  logic prev_valid = 1'b0;

  int line_tbl [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                          '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  int fb_order [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};

  // Reference: try to complete a line for the computer, then for the player,
  // else take the first empty cell in preference order.
  function automatic void model(input logic [17:0] b, output logic [3:0] mv, output int lat);
    logic found = 1'b0;
    mv  = 4'hF;
    lat = 18;
    for (int ph = 0; ph < 2; ph++) begin
      for (int l = 0; l < 8; l++) begin
        int nt = 0;
        int ne = 0;
        int ei = 0;
        for (int k = 0; k < 3; k++) begin
          logic [1:0] c;
          c = b[2*line_tbl[l][k] +: 2];
          if (c == ((ph == 0) ? 2'b10 : 2'b01)) nt++;
          if (c == 2'b00) begin ne++; ei = line_tbl[l][k]; end
        end
        if (!found && nt == 2 && ne == 1) begin
          found = 1'b1;
          mv    = 4'(ei);
          lat   = 2 + 8*ph + l;
        end
      end
    end
    for (int k = 0; k < 9; k++) begin
      if (!found && b[2*fb_order[k] +: 2] == 2'b00) begin
        found = 1'b1;
        mv    = 4'(fb_order[k]);
      end
    end
  endfunction

  function automatic void chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, cyc, act, exp_v);
    end
  endfunction

  // Edge counter plus the control inputs as the DUT sampled them.
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rst_at <= reset;
    gs_at  <= gamemode_switch;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (!rst_at) begin
      q.delete();
      hold_exp = 4'hF;
      chk("reset_valid", int'(comp_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_comp_inp", int'(comp_inp), 15);
    end else begin
      if (q.size() > 0 && !gs_at && q[0].start < cyc && cyc <= q[0].start + q[0].lat)
        void'(q.pop_front());
      if (comp_valid === 1'b1) begin
        chk("valid_back_to_back", int'(prev_valid), 0);
        if (q.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("move", int'(comp_inp), int'(e.move));
          chk("latency", cyc - e.start, e.lat);
          hold_exp = e.move;
        end
      end else if (q.size() > 0 && cyc >= q[0].start + q[0].lat) begin
        chk("missing_valid", 0, 1);
        void'(q.pop_front());
      end
      chk("comp_inp_hold", int'(comp_inp), int'(hold_exp));
      chk("busy", int'(busy), int'(q.size() > 0 && q[0].start <= cyc));
    end
    prev_valid = comp_valid;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [17:0] b);
    logic [3:0] mv;
    int lat;
    int w = 0;
    while (q.size() > 0 && w < 60) begin step(); w++; end
    if (q.size() > 0) begin
      $display("FAIL issue_timeout: queue still holds %0d entries", q.size());
      $fatal(1, "scoreboard did not drain");
    end
    model(b, mv, lat);
    board = b;
    req   = 1'b1;
    q.push_back('{start: cyc + 1, lat: lat, move: mv});
    step();
    req = 1'b0;
  endtask

  function automatic logic [17:0] b9(input logic [1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
    return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  function automatic logic [17:0] rand_board();
    logic [17:0] b;
    for (int i = 0; i < 9; i++) begin
      int r = $urandom_range(0, 9);
      b[2*i +: 2] = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
    end
    return b;
  endfunction

  localparam logic [1:0] E = 2'b00, P = 2'b01, C = 2'b10, X = 2'b11;

  initial begin
    repeat (3) step();
    reset = 1'b1;
    step();
    // Directed scenarios.
    issue(b9(C, C, E, P, P, E, E, E, E));   // win line 0 beats block
    issue(b9(P, P, E, E, C, E, E, E, E));   // block line 0
    issue(b9(E, E, E, E, E, E, E, E, E));   // empty board -> centre
    issue(b9(P, E, C, E, X, E, E, E, E));   // centre/corners taken -> 6
    issue(b9(C, P, C, C, P, P, P, C, C));   // full board -> NO_MOVE
    issue(b9(C, C, E, E, E, E, C, C, E));   // two wins, lowest line
    // Board changes and a second req while busy.
    issue(b9(E, E, E, E, E, E, E, E, E));
    board = 18'h3FFFF;
    step();
    req = 1'b1;
    step();
    req = 1'b0;
    // Mode drop mid-search: no result, comp_inp keeps the last move.
    issue(b9(E, E, E, E, E, E, E, E, E));
    repeat (3) step();
    gamemode_switch = 1'b0;
    step();
    gamemode_switch = 1'b1;
    repeat (3) step();
    // Reset at latency 5 of a search.
    issue(b9(E, E, E, E, E, E, E, E, E));
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    repeat (3) step();
    // Randomized requests with disturbances while busy.
    for (int it = 0; it < 200; it++) begin
      logic dead = 1'b0;
      issue(rand_board());
      for (int w = 0; w < 40 && q.size() > 0; w++) begin
        int r = $urandom_range(0, 99);
        board = rand_board();
        if (!dead && r < 2) begin
          reset = 1'b0; dead = 1'b1;
        end else if (!dead && r < 5) begin
          gamemode_switch = 1'b0; dead = 1'b1;
        end else if (!dead && r < 30 && q[0].start + q[0].lat >= cyc + 1) begin
          req = 1'b1;
        end
        step();
        reset = 1'b1;
        gamemode_switch = 1'b1;
        req = 1'b0;
      end
    end
    repeat (25) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
